// File: rtl/pipeline_processor.sv
// Four-stage (IF/ID/EX/WB) 16-bit processor: ADD, SUB, LOAD-imm over a 4-entry register file.
// Define PIPE_FORWARD_EN to add the EX/WB -> EX operand forwarding path.
module pipeline_processor #(
  parameter int IMEM_DEPTH = 256
) (
  input logic clk,
  input logic reset
);
  localparam int PCW    = $clog2(IMEM_DEPTH);
  localparam int STAGES = 2;
  localparam logic [3:0] OP_ADD  = 4'h1;
  localparam logic [3:0] OP_SUB  = 4'h2;
  localparam logic [3:0] OP_LOAD = 4'h3;

  typedef struct packed {
    logic [3:0] op;
    logic [1:0] rd;
    logic [1:0] rs;
    logic [7:0] imm;
  } instr_t;

  typedef struct packed {
    logic        we;
    logic        sub;
    logic        load;
    logic [1:0]  rd;
`ifdef PIPE_FORWARD_EN
    logic [1:0]  rs;
`endif
    logic [7:0]  imm;
    logic [15:0] a;
    logic [15:0] b;
  } idex_t;

  typedef struct packed {
    logic        we;
    logic [1:0]  rd;
    logic [15:0] res;
  } exwb_t;

  // Loaded hierarchically by the bench; deliberately has no reset.
  logic [15:0]    instruction_memory [0:IMEM_DEPTH-1];
  logic [15:0]    register_file [0:3];
  logic [PCW-1:0] PC;

  instr_t         if_id;
  idex_t          id_ex, id_next;
  exwb_t          ex_wb, ex_next;
  // Bit 0..STAGES: IF/ID, ID/EX, EX/WB hold a fetched instruction.
  logic [STAGES:0] vld_pipe;

  logic           wb_we;
  logic [15:0]    id_a, id_b, ex_a, ex_b;
  logic [PCW-1:0] pc_next;

  assign wb_we   = ex_wb.we && vld_pipe[2];
  assign pc_next = (PC == PCW'(IMEM_DEPTH - 1)) ? '0 : PC + 1'b1;

  // ID: register read with write-through bypass from the WB stage.
  always_comb begin
    id_a = register_file[if_id.rd];
    id_b = register_file[if_id.rs];
    if (wb_we && ex_wb.rd == if_id.rd) id_a = ex_wb.res;
    if (wb_we && ex_wb.rd == if_id.rs) id_b = ex_wb.res;

    id_next      = '0;
    id_next.we   = vld_pipe[0] &&
                   (if_id.op == OP_ADD || if_id.op == OP_SUB || if_id.op == OP_LOAD);
    id_next.sub  = (if_id.op == OP_SUB);
    id_next.load = (if_id.op == OP_LOAD);
    id_next.rd   = if_id.rd;
`ifdef PIPE_FORWARD_EN
    id_next.rs   = if_id.rs;
`endif
    id_next.imm  = if_id.imm;
    id_next.a    = id_a;
    id_next.b    = id_b;
  end

  // EX: the instruction one ahead sits in EX/WB and has not reached the file yet.
  always_comb begin
    ex_a = id_ex.a;
    ex_b = id_ex.b;
`ifdef PIPE_FORWARD_EN
    if (wb_we && ex_wb.rd == id_ex.rd) ex_a = ex_wb.res;
    if (wb_we && ex_wb.rd == id_ex.rs) ex_b = ex_wb.res;
`endif
    ex_next     = '0;
    ex_next.we  = id_ex.we && vld_pipe[1];
    ex_next.rd  = id_ex.rd;
    if (id_ex.load)     ex_next.res = {8'h00, id_ex.imm};
    else if (id_ex.sub) ex_next.res = ex_a - ex_b;
    else                ex_next.res = ex_a + ex_b;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      PC       <= '0;
      if_id    <= '0;
      id_ex    <= '0;
      ex_wb    <= '0;
      vld_pipe <= '0;
    end else begin
      PC       <= pc_next;
      if_id    <= instr_t'(instruction_memory[PC]);
      id_ex    <= id_next;
      ex_wb    <= ex_next;
      vld_pipe <= {vld_pipe[STAGES-1:0], 1'b1};
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 4; i++) register_file[i] <= '0;
    end else if (wb_we) begin
      register_file[ex_wb.rd] <= ex_wb.res;
    end
  end

endmodule

// File: tb/tb_pipeline_processor.sv
// Directed-vector bench for pipeline_processor; expectations follow PIPE_FORWARD_EN.
module tb_pipeline_processor;
  logic clk;
  logic reset;
  int   n_chk;
  int   n_pass;

  pipeline_processor #(.IMEM_DEPTH(256)) dut (
    .clk   (clk),
    .reset (reset)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h exp %h", tag, got, exp);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Release on a falling edge so the next rising edge is edge 1.
  task automatic do_reset();
    reset = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 256; i++) dut.instruction_memory[i] = 16'h0000;
  endtask

  initial begin
    logic [15:0] exp_add, exp_sub;
    n_chk  = 0;
    n_pass = 0;
    reset  = 1'b1;
    #2;

    // Reset state and NOP-only memory
    clear_mem();
    reset = 1'b0;
    #1;
    chk("rst_pc", 16'(dut.PC), 16'h0000);
    chk("rst_r0", dut.register_file[0], 16'h0000);
    do_reset();
    step(4);
    chk("nop_pc4", 16'(dut.PC), 16'h0004);
    for (int r = 0; r < 4; r++) chk($sformatf("nop_r%0d", r), dut.register_file[r], 16'h0000);

    // LOAD/LOAD/ADD/SUB with distance-1 and distance-2 dependences
`ifdef PIPE_FORWARD_EN
    exp_add = 16'd25;
    exp_sub = 16'd10;
`else
    exp_add = 16'd10;
    exp_sub = 16'hFFFB;
`endif
    clear_mem();
    dut.instruction_memory[0] = 16'h300A;
    dut.instruction_memory[1] = 16'h340F;
    dut.instruction_memory[2] = 16'h1100;
    dut.instruction_memory[3] = 16'h2100;
    do_reset();
    step(4);
    chk("prog_e4_r0", dut.register_file[0], 16'd10);
    chk("prog_e4_r1", dut.register_file[1], 16'd0);
    step(1);
    chk("prog_e5_r1", dut.register_file[1], 16'd15);
    step(1);
    chk("prog_e6_add", dut.register_file[0], exp_add);
    step(1);
    chk("prog_e7_sub", dut.register_file[0], exp_sub);

    // Underflow and undefined opcode
    clear_mem();
    dut.instruction_memory[0] = 16'h3803;  // LOAD R2,3
    dut.instruction_memory[3] = 16'h2A00;  // SUB R2,R2
    dut.instruction_memory[4] = 16'h3401;  // LOAD R1,1
    dut.instruction_memory[5] = 16'hF5FF;  // undefined
    dut.instruction_memory[7] = 16'h2D00;  // SUB R3,R1
    do_reset();
    step(4);
    chk("uf_e4_r2", dut.register_file[2], 16'd3);
    step(3);
    chk("uf_e7_r2", dut.register_file[2], 16'd0);
    step(1);
    chk("uf_e8_r1", dut.register_file[1], 16'd1);
    step(3);
    chk("uf_e11_r3", dut.register_file[3], 16'hFFFF);
    chk("undef_r1", dut.register_file[1], 16'd1);
    chk("undef_r0", dut.register_file[0], 16'd0);
    chk("undef_r2", dut.register_file[2], 16'd0);

    // PC wrap
    do_reset();
    step(255);
    chk("pc_255", 16'(dut.PC), 16'h00FF);
    step(1);
    chk("pc_wrap", 16'(dut.PC), 16'h0000);

    // Async reset with LOAD R2,5 in EX
    clear_mem();
    dut.instruction_memory[0] = 16'h3C07;  // LOAD R3,7
    dut.instruction_memory[4] = 16'h3805;  // LOAD R2,5
    do_reset();
    step(6);
    chk("ar_r3_before", dut.register_file[3], 16'd7);
    #2;
    reset = 1'b0;
    #1;
    chk("ar_pc_now", 16'(dut.PC), 16'h0000);
    chk("ar_r3_now", dut.register_file[3], 16'd0);
    dut.instruction_memory[4] = 16'h0000;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    step(2);
    chk("ar_pc2", 16'(dut.PC), 16'h0002);
    chk("ar_no_wb_r2", dut.register_file[2], 16'd0);
    step(3);
    chk("ar_r3_again", dut.register_file[3], 16'd7);
    chk("ar_r2_still0", dut.register_file[2], 16'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
